data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 118 +++++++++++
 tb/tb_data_mem_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the KGP-RISC datapath.
// Accepts one load or store per instruction, models a word-addressed RAM with
// a fixed access latency, and holds stall high until the access completes.
module data_mem_responder #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] writeData,
   output logic [DATA_W-1:0] readData,
   output logic              stall,
   output logic              alignErr
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q;
   logic [3:0]          cnt_q;
   logic [ADDR_W+1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                wr_q;
   logic [DATA_W-1:0]   read_data_q;
   logic                align_err_q;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                req;
   logic                last_busy;
   logic [ADDR_W-1:0]   word_idx;
   logic                unused_addr_hi;

   // Request decode, word index of the latched address and the commit cycle.
   always_comb begin
      req       = memRead | memWrite;
      last_busy = (state_q == BUSY) && (cnt_q == 4'd1);
      word_idx  = addr_q[ADDR_W+1:2];
   end

   // Byte-address bits above the word index wrap modulo depth and are dropped.
   assign unused_addr_hi = ^addr[31:ADDR_W+2];

   // Control FSM: latch the request, count down the latency, present results in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wr_q        <= 1'b0;
         read_data_q <= '0;
         align_err_q <= 1'b0;
      end else begin
         // NOTE: every register here is sequential state, so only non-blocking
         // assignments are used; the default below makes alignErr a one-cycle pulse.
         align_err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req) begin
                  addr_q  <= addr[ADDR_W+1:0];
                  wdata_q <= writeData;
                  wr_q    <= memWrite;   // both high counts as a store
                  cnt_q   <= 4'(LATENCY);
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               cnt_q <= cnt_q - 4'd1;
               if (last_busy) begin
                  state_q     <= DONE;
                  align_err_q <= |addr_q[1:0];
                  if (!wr_q) begin
                     read_data_q <= mem[word_idx];
                  end
               end
            end
            DONE: begin
               // Request lines still carry the completing instruction: ignore them.
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Store commit on the final BUSY edge; a coincident reset aborts it.
   always_ff @(posedge clk) begin
      // NOTE: the RAM array is deliberately left out of reset; only the commit
      // is gated, which keeps it mappable onto a plain memory macro.
      if (!rst && last_busy && wr_q) begin
         mem[word_idx] <= wdata_q;
      end
   end

   // Stall: combinational in IDLE so the request cycle itself is held, forced low in reset.
   always_comb begin
      stall = 1'b0;
      if (!rst) begin
         stall = (state_q == BUSY) || ((state_q == IDLE) && req);
      end
   end

   assign readData = read_data_q;
   assign alignErr = align_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a transaction-level model tracks
// the cycle offset of each access and the memory image; a per-cycle compare
// process checks stall/readData/alignErr, and directed scenarios add literal checks.
module tb_data_mem_responder;

   localparam int LAT = 2;
   localparam int DW  = 32;
   localparam int AW  = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          memRead;
   logic          memWrite;
   logic [31:0]   addr;
   logic [DW-1:0] writeData;
   logic [DW-1:0] readData;
   logic          stall;
   logic          alignErr;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   data_mem_responder #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .LATENCY (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .memRead   (memRead),
      .memWrite  (memWrite),
      .addr      (addr),
      .writeData (writeData),
      .readData  (readData),
      .stall     (stall),
      .alignErr  (alignErr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   // m_phase: -1 when no access is in flight, otherwise cycles elapsed since the
   // request cycle (1..LAT busy, LAT+1 result cycle).
   int          m_phase = -1;
   logic [31:0] m_addr;
   logic [31:0] m_data;
   bit          m_wr;
   logic [31:0] m_rd;
   bit          m_rd_known = 1'b0;
   bit          checking = 1'b0;
   bit [31:0]   m_mem   [1 << AW];
   bit          m_known [1 << AW];

   function automatic int word_of(input logic [31:0] a);
      return int'((a >> 2) % (1 << AW));
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_phase    <= -1;
         m_rd       <= '0;
         m_rd_known <= 1'b1;
         checking   <= 1'b1;
      end else if (m_phase < 0) begin
         if (memRead || memWrite) begin
            m_addr  <= addr;
            m_data  <= writeData;
            m_wr    <= memWrite;
            m_phase <= 1;
         end
      end else if (m_phase == LAT) begin
         if (m_wr) begin
            m_mem[word_of(m_addr)]   <= m_data;
            m_known[word_of(m_addr)] <= 1'b1;
         end else begin
            m_rd       <= m_mem[word_of(m_addr)];
            m_rd_known <= m_known[word_of(m_addr)];
         end
         m_phase <= LAT + 1;
      end else if (m_phase == LAT + 1) begin
         m_phase <= -1;
      end else begin
         m_phase <= m_phase + 1;
      end
   end

   // Per-cycle compare, sampled on the falling edge.
   always @(negedge clk) begin
      if (checking) begin
         logic exp_stall;
         logic exp_ae;
         if (rst)              exp_stall = 1'b0;
         else if (m_phase < 0) exp_stall = memRead | memWrite;
         else                  exp_stall = (m_phase <= LAT);
         exp_ae = (m_phase == LAT + 1) && (m_addr[1:0] != 2'b00);
         check("cyc_stall", {31'd0, stall}, {31'd0, exp_stall});
         check("cyc_alignErr", {31'd0, alignErr}, {31'd0, exp_ae});
         if (m_rd_known) check("cyc_readData", readData, m_rd);
      end
   end

   // ---------------- stimulus ----------------
   // Called #1 after a rising edge; holds the request through the result cycle.
   task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, output logic [31:0] rd_done,
                            output logic ae_done, output int stall_cnt, output int ae_cnt);
      memRead   = rd;
      memWrite  = wr;
      addr      = a;
      writeData = d;
      stall_cnt = 0;
      ae_cnt    = 0;
      rd_done   = '0;
      ae_done   = 1'b0;
      for (int i = 0; i < LAT + 2; i++) begin
         @(negedge clk);
         if (stall)    stall_cnt++;
         if (alignErr) ae_cnt++;
         if (i == LAT + 1) begin
            rd_done = readData;
            ae_done = alignErr;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      memRead  = 1'b0;
      memWrite = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [31:0] rdv;
      logic        ae;
      int          sc;
      int          ac;

      rst       = 1'b1;
      memRead   = 1'b1;
      memWrite  = 1'b0;
      addr      = 32'h0;
      writeData = 32'h0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst     = 1'b0;
      memRead = 1'b0;
      @(negedge clk);
      check("reset_stall", {31'd0, stall}, 32'd0);
      check("reset_readData", readData, 32'h0);
      check("reset_alignErr", {31'd0, alignErr}, 32'd0);
      @(posedge clk);
      #1;

      // Store then load, same address.
      do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rdv, ae, sc, ac);
      check("store_stall_cycles", sc, LAT + 1);
      check("store_alignErr", {31'd0, ae}, 32'd0);
      do_access(1'b1, 1'b0, 32'h10, 32'h0, rdv, ae, sc, ac);
      check("load_stall_cycles", sc, LAT + 1);
      check("load_readData", rdv, 32'hDEADBEEF);
      idle(1);

      // Misaligned store with address wrap to word 0.
      do_access(1'b0, 1'b1, 32'h1003, 32'h12345678, rdv, ae, sc, ac);
      check("misalign_alignErr", {31'd0, ae}, 32'd1);
      check("misalign_pulses", ac, 1);
      idle(1);
      do_access(1'b1, 1'b0, 32'h0, 32'h0, rdv, ae, sc, ac);
      check("wrap_readData", rdv, 32'h12345678);
      check("wrap_alignErr", {31'd0, ae}, 32'd0);
      idle(1);

      // Read and write both high: a store, readData untouched.
      do_access(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, rdv, ae, sc, ac);
      check("conflict_readData_held", rdv, 32'h12345678);
      idle(1);
      do_access(1'b1, 1'b0, 32'h20, 32'h0, rdv, ae, sc, ac);
      check("conflict_load", rdv, 32'hA5A5A5A5);
      idle(1);

      // Abort: reset on the final BUSY edge cancels the store.
      do_access(1'b0, 1'b1, 32'h40, 32'h0, rdv, ae, sc, ac);
      idle(1);
      memWrite  = 1'b1;
      addr      = 32'h40;
      writeData = 32'h55;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst      = 1'b1;
      memWrite = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_readData_reset", readData, 32'h0);
      idle(1);
      do_access(1'b1, 1'b0, 32'h40, 32'h0, rdv, ae, sc, ac);
      check("abort_load", rdv, 32'h0);
      idle(1);

      // Back-to-back loads.
      do_access(1'b0, 1'b1, 32'h4, 32'h11111111, rdv, ae, sc, ac);
      do_access(1'b0, 1'b1, 32'h8, 32'h22222222, rdv, ae, sc, ac);
      idle(1);
      do_access(1'b1, 1'b0, 32'h4, 32'h0, rdv, ae, sc, ac);
      check("b2b_first", rdv, 32'h11111111);
      do_access(1'b1, 1'b0, 32'h8, 32'h0, rdv, ae, sc, ac);
      check("b2b_second", rdv, 32'h22222222);
      check("b2b_stall_cycles", sc, LAT + 1);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
